// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I datapath with a memory-ready handshake and a sticky fault.
// Optional retired-instruction counter: define MC_RETIRE_CNT_EN to add the RetireCount output.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Instr,
   input  logic        Zero,
   input  logic        Negative,
   input  logic        MemReady,
   output logic        MemReq,
   output logic        AdrSrc,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        RegWrite,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [4:0]  ALUControl,
   output logic [2:0]  ImmSrc,
   output logic        InstrDone,
   output logic        Fault
`ifdef MC_RETIRE_CNT_EN
   ,
   output logic [CNT_W-1:0] RetireCount
`endif
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   localparam logic [4:0] ALU_ADD = 5'b00000;
   localparam logic [4:0] ALU_SUB = 5'b00001;
   localparam logic [4:0] ALU_AND = 5'b00010;
   localparam logic [4:0] ALU_OR  = 5'b00011;
   localparam logic [4:0] ALU_SLT = 5'b00101;
   localparam logic [4:0] ALU_SLL = 5'b00110;
   localparam logic [4:0] ALU_SRL = 5'b00111;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
      S_ALUWB, S_BRANCH, S_JAL, S_JALR_CALC, S_JALR_LINK, S_LUI, S_FAULT
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              timeout;
   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic              unused_instr;

   assign opcode       = Instr[6:0];
   assign funct3       = Instr[14:12];
   assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};
   // Fires on the cycle that would be the MEM_TIMEOUT-th consecutive not-ready cycle.
   assign timeout      = (MEM_TIMEOUT != 0) && (int'(wait_q) == MEM_TIMEOUT - 1);

   always_comb begin
      MemReq = 1'b0;  AdrSrc = 1'b0;  MemWrite = 1'b0;  IRWrite = 1'b0;
      PCWrite = 1'b0; RegWrite = 1'b0; InstrDone = 1'b0; Fault = 1'b0;
      ResultSrc = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00;
      ALUControl = ALU_ADD; ImmSrc = 3'b000;
      state_d = state_q;
      wait_d  = '0;
      case (state_q)
         S_FETCH: begin
            MemReq = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            IRWrite = MemReady; PCWrite = MemReady;
            if (MemReady)     state_d = S_DECODE;
            else if (timeout) state_d = S_FAULT;
            else              wait_d  = wait_q + 1'b1;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01; ALUSrcB = 2'b01;
            ImmSrc  = (opcode == OP_JAL) ? 3'b011 : 3'b010;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXECR;
               OP_I:              state_d = S_EXECI;
               OP_BR:             state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR_CALC;
               OP_LUI:            state_d = S_LUI;
               default:           state_d = S_FAULT;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10; ALUSrcB = 2'b01;
            ImmSrc  = (opcode == OP_STORE) ? 3'b001 : 3'b000;
            if (funct3 != 3'b010)       state_d = S_FAULT;
            else if (opcode == OP_STORE) state_d = S_MEMWRITE;
            else                         state_d = S_MEMREAD;
         end
         S_MEMREAD: begin
            MemReq = 1'b1; AdrSrc = 1'b1;
            if (MemReady)     state_d = S_MEMWB;
            else if (timeout) state_d = S_FAULT;
            else              wait_d  = wait_q + 1'b1;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01; RegWrite = 1'b1; InstrDone = 1'b1;
            state_d = S_FETCH;
         end
         S_MEMWRITE: begin
            MemReq = 1'b1; AdrSrc = 1'b1; MemWrite = 1'b1;
            InstrDone = MemReady;
            if (MemReady)     state_d = S_FETCH;
            else if (timeout) state_d = S_FAULT;
            else              wait_d  = wait_q + 1'b1;
         end
         S_EXECR, S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = (state_q == S_EXECR) ? 2'b00 : 2'b01;
            state_d = S_ALUWB;
            case (funct3)
               3'b000:  ALUControl = (state_q == S_EXECR && Instr[30]) ? ALU_SUB : ALU_ADD;
               3'b001:  ALUControl = ALU_SLL;
               3'b010:  ALUControl = ALU_SLT;
               3'b101:  ALUControl = ALU_SRL;
               3'b110:  ALUControl = ALU_OR;
               3'b111:  ALUControl = ALU_AND;
               default: state_d = S_FAULT;
            endcase
         end
         S_ALUWB: begin
            RegWrite = 1'b1; InstrDone = 1'b1;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA = 2'b10; ALUControl = ALU_SUB;
            InstrDone = 1'b1;
            state_d = S_FETCH;
            case (funct3)
               3'b000:  PCWrite = Zero;
               3'b001:  PCWrite = ~Zero;
               3'b100:  PCWrite = Negative;
               3'b101:  PCWrite = ~Negative;
               default: begin
                  InstrDone = 1'b0;
                  state_d   = S_FAULT;
               end
            endcase
         end
         S_JAL, S_JALR_LINK: begin
            // OldPC+4 is computed for the link write while PC takes the target held in ALUOut.
            ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1;
            state_d = S_ALUWB;
         end
         S_JALR_CALC: begin
            ALUSrcA = 2'b10; ALUSrcB = 2'b01;
            state_d = S_JALR_LINK;
         end
         S_LUI: begin
            ALUSrcA = 2'b11; ALUSrcB = 2'b01; ImmSrc = 3'b100;
            state_d = S_ALUWB;
         end
         S_FAULT: Fault = 1'b1;
         default: state_d = S_FAULT;
      endcase
      // Reset forces every output low without waiting for a clock edge.
      if (rst) begin
         MemReq = 1'b0;  AdrSrc = 1'b0;  MemWrite = 1'b0;  IRWrite = 1'b0;
         PCWrite = 1'b0; RegWrite = 1'b0; InstrDone = 1'b0; Fault = 1'b0;
         ResultSrc = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00;
         ALUControl = ALU_ADD; ImmSrc = 3'b000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

`ifdef MC_RETIRE_CNT_EN
   logic [CNT_W-1:0] retire_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            retire_q <= '0;
      else if (InstrDone) retire_q <= retire_q + 1'b1;
   end

   assign RetireCount = retire_q;
`else
   localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-by-cycle scoreboard bench for multicycle_ctrl (MEM_TIMEOUT=8); RetireCount checks
// are compiled in when MC_RETIRE_CNT_EN is defined.
module tb_multicycle_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] Instr = '0;
   logic        Zero = 1'b0, Negative = 1'b0, MemReady = 1'b0;
   logic        MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, InstrDone, Fault;
   logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
   logic [4:0]  ALUControl;
   logic [2:0]  ImmSrc;
`ifdef MC_RETIRE_CNT_EN
   logic [31:0] RetireCount;
`endif

   multicycle_ctrl #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .Instr(Instr), .Zero(Zero), .Negative(Negative),
      .MemReady(MemReady), .MemReq(MemReq), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
      .InstrDone(InstrDone), .Fault(Fault)
`ifdef MC_RETIRE_CNT_EN
      , .RetireCount(RetireCount)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
      logic [1:0] result_src, src_a, src_b;
      logic [4:0] alu;
      logic [2:0] imm;
      logic       done, fault;
   } out_t;

   out_t obs;
   assign obs = {MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUControl, ImmSrc, InstrDone, Fault};

   out_t  sb_q[$];
   string sb_tag_q[$];
   int    n_checks = 0;
   int    n_pass = 0;
   int    n_cyc = 0;

   // Expected output bundles per controller step, straight from the state output table.
   function automatic out_t f_fetch(input logic mr);
      out_t e = '0;
      e.mem_req = 1'b1; e.src_b = 2'b10; e.result_src = 2'b10;
      e.ir_write = mr; e.pc_write = mr;
      return e;
   endfunction
   function automatic out_t f_decode(input logic is_jal);
      out_t e = '0;
      e.src_a = 2'b01; e.src_b = 2'b01; e.imm = is_jal ? 3'b011 : 3'b010;
      return e;
   endfunction
   function automatic out_t f_memadr(input logic is_store);
      out_t e = '0;
      e.src_a = 2'b10; e.src_b = 2'b01; e.imm = is_store ? 3'b001 : 3'b000;
      return e;
   endfunction
   function automatic out_t f_memread();
      out_t e = '0;
      e.mem_req = 1'b1; e.adr_src = 1'b1;
      return e;
   endfunction
   function automatic out_t f_memwb();
      out_t e = '0;
      e.result_src = 2'b01; e.reg_write = 1'b1; e.done = 1'b1;
      return e;
   endfunction
   function automatic out_t f_memwrite(input logic mr);
      out_t e = '0;
      e.mem_req = 1'b1; e.adr_src = 1'b1; e.mem_write = 1'b1; e.done = mr;
      return e;
   endfunction
   function automatic out_t f_exec(input logic is_r, input logic [4:0] alu);
      out_t e = '0;
      e.src_a = 2'b10; e.src_b = is_r ? 2'b00 : 2'b01; e.alu = alu;
      return e;
   endfunction
   function automatic out_t f_aluwb();
      out_t e = '0;
      e.reg_write = 1'b1; e.done = 1'b1;
      return e;
   endfunction
   function automatic out_t f_branch(input logic pcw);
      out_t e = '0;
      e.src_a = 2'b10; e.alu = 5'b00001; e.pc_write = pcw; e.done = 1'b1;
      return e;
   endfunction
   function automatic out_t f_jal();
      out_t e = '0;
      e.src_a = 2'b01; e.src_b = 2'b10; e.pc_write = 1'b1;
      return e;
   endfunction
   function automatic out_t f_jalrc();
      out_t e = '0;
      e.src_a = 2'b10; e.src_b = 2'b01;
      return e;
   endfunction
   function automatic out_t f_lui();
      out_t e = '0;
      e.src_a = 2'b11; e.src_b = 2'b01; e.imm = 3'b100;
      return e;
   endfunction
   function automatic out_t f_fault();
      out_t e = '0;
      e.fault = 1'b1;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // One controller cycle: drive inputs, queue the expectation, compare 1 ns later.
   task automatic cyc(input logic mr, input out_t e, input string tag);
      out_t  x;
      string t;
      MemReady = mr;
      sb_q.push_back(e);
      sb_tag_q.push_back(tag);
      #1;
      x = sb_q.pop_front();
      t = sb_tag_q.pop_front();
      check(t, 32'(obs), 32'(x));
      n_cyc++;
      @(negedge clk);
   endtask

   task automatic skip(input logic mr);
      MemReady = mr;
      #1;
      n_cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      MemReady = 1'b1;
      #1;
      check("reset_outs", 32'(obs), 32'd0);
`ifdef MC_RETIRE_CNT_EN
      check("reset_retire", RetireCount, 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      MemReady = 1'b0;
      n_cyc = 0;
   endtask

   task automatic begin_instr(input logic [31:0] ins);
      Instr = ins;
      n_cyc = 0;
   endtask

   task automatic end_instr(input string name, input int exp_cyc);
      check({name, "_cycles"}, 32'(n_cyc), 32'(exp_cyc));
      $display("instr %-7s %h : %0d cycles", name, Instr, n_cyc);
   endtask

   logic [31:0] alu_ins [0:7] = '{32'h00000033, 32'h40000033, 32'h00007033, 32'h00006033,
                                  32'h00005033, 32'h00001033, 32'h00002013, 32'h00000013};
   logic [4:0]  alu_exp [0:7] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                                  5'b00111, 5'b00110, 5'b00101, 5'b00000};
   logic        alu_r   [0:7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   task automatic run_alu(input int i);
      begin_instr(alu_ins[i]);
      cyc(1'b1, f_fetch(1'b1), "alu_fetch");
      cyc(1'b0, f_decode(1'b0), "alu_decode");
      cyc(1'b0, f_exec(alu_r[i], alu_exp[i]), "alu_exec");
      cyc(1'b0, f_aluwb(), "alu_wb");
      end_instr("alu", 4);
   endtask

   logic [31:0] br_ins [0:5] = '{32'h00001063, 32'h00001063, 32'h00005063,
                                 32'h00005063, 32'h00000063, 32'h00004063};
   logic        br_z   [0:5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic        br_n   [0:5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic        br_pcw [0:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   task automatic run_fault(input logic [31:0] ins, input string name, input logic mid,
                            input int hold);
      begin_instr(ins);
      cyc(1'b1, f_fetch(1'b1), {name, "_fetch"});
      cyc(1'b0, f_decode(1'b0), {name, "_decode"});
      if (mid) skip(1'b0);
      for (int k = 0; k < hold; k++) cyc(1'b0, f_fault(), {name, "_fault"});
      $display("instr %-7s %h : fault held %0d cycles", name, ins, hold);
      do_reset();
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      for (int i = 0; i < 8; i++) run_alu(i);

      // addi with a 7-cycle fetch stall: one short of the timeout
      begin_instr(32'h00000013);
      for (int k = 0; k < 7; k++) cyc(1'b0, f_fetch(1'b0), "stall_fetch");
      cyc(1'b1, f_fetch(1'b1), "stall_fetch_rdy");
      cyc(1'b0, f_decode(1'b0), "stall_decode");
      cyc(1'b0, f_exec(1'b0, 5'b00000), "stall_exec");
      cyc(1'b0, f_aluwb(), "stall_wb");
      end_instr("addi_st", 11);

      begin_instr(32'h00002003);
      cyc(1'b1, f_fetch(1'b1), "lw_fetch");
      cyc(1'b0, f_decode(1'b0), "lw_decode");
      cyc(1'b0, f_memadr(1'b0), "lw_memadr");
      for (int k = 0; k < 3; k++) cyc(1'b0, f_memread(), "lw_memread_wait");
      cyc(1'b1, f_memread(), "lw_memread");
      cyc(1'b0, f_memwb(), "lw_memwb");
      end_instr("lw", 8);

      begin_instr(32'h00002023);
      cyc(1'b1, f_fetch(1'b1), "sw_fetch");
      cyc(1'b0, f_decode(1'b0), "sw_decode");
      cyc(1'b0, f_memadr(1'b1), "sw_memadr");
      cyc(1'b0, f_memwrite(1'b0), "sw_memwrite_wait");
      cyc(1'b1, f_memwrite(1'b1), "sw_memwrite");
      end_instr("sw", 5);

      for (int i = 0; i < 6; i++) begin
         begin_instr(br_ins[i]);
         Zero = br_z[i];
         Negative = br_n[i];
         cyc(1'b1, f_fetch(1'b1), "br_fetch");
         cyc(1'b0, f_decode(1'b0), "br_decode");
         cyc(1'b0, f_branch(br_pcw[i]), "br_exec");
         end_instr("branch", 3);
      end
      Zero = 1'b0;
      Negative = 1'b0;

      begin_instr(32'h0000006f);
      cyc(1'b1, f_fetch(1'b1), "jal_fetch");
      cyc(1'b0, f_decode(1'b1), "jal_decode");
      cyc(1'b0, f_jal(), "jal_jal");
      cyc(1'b0, f_aluwb(), "jal_wb");
      end_instr("jal", 4);

      begin_instr(32'h00000067);
      cyc(1'b1, f_fetch(1'b1), "jalr_fetch");
      cyc(1'b0, f_decode(1'b0), "jalr_decode");
      cyc(1'b0, f_jalrc(), "jalr_calc");
      cyc(1'b0, f_jal(), "jalr_link");
      cyc(1'b0, f_aluwb(), "jalr_wb");
      end_instr("jalr", 5);

      begin_instr(32'h00000037);
      cyc(1'b1, f_fetch(1'b1), "lui_fetch");
      cyc(1'b0, f_decode(1'b0), "lui_decode");
      cyc(1'b0, f_lui(), "lui_lui");
      cyc(1'b0, f_aluwb(), "lui_wb");
      end_instr("lui", 4);

      run_fault(32'h00000000, "illegal", 1'b0, 20);
      run_fault(32'h00000003, "lb", 1'b1, 3);
      run_fault(32'h00003013, "sltiu", 1'b1, 3);
      run_fault(32'h00002063, "bad_br", 1'b1, 3);

      // fetch timeout: 8 not-ready cycles, fault visible on cycle index 8
      begin_instr(32'h00000033);
      for (int k = 0; k < 8; k++) cyc(1'b0, f_fetch(1'b0), "to_fetch");
      for (int k = 0; k < 3; k++) cyc(1'b0, f_fault(), "to_fault");
      $display("fetch timeout : fault after %0d wait cycles", 8);
      do_reset();

      // reset asserted in the middle of a load
      begin_instr(32'h00002003);
      cyc(1'b1, f_fetch(1'b1), "rm_fetch");
      cyc(1'b0, f_decode(1'b0), "rm_decode");
      cyc(1'b0, f_memadr(1'b0), "rm_memadr");
      cyc(1'b0, f_memread(), "rm_memread");
      rst = 1'b1;
      MemReady = 1'b1;
      #1;
      check("rst_mid_outs", 32'(obs), 32'd0);
      $display("instr %-7s %h : abandoned by reset in MEMREAD", "lw", Instr);
      @(negedge clk);
      rst = 1'b0;
      run_alu(0);

`ifdef MC_RETIRE_CNT_EN
      do_reset();
      run_alu(0);
      run_alu(6);
      run_alu(3);
      #1;
      check("retire_cnt", RetireCount, 32'd3);
      @(negedge clk);
      do_reset();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
